// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one FIFO write port among N_REQ
// valid/ready producers. Define ARB_STATS_EN to add per-requester transfer counters.
module fifo_write_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            req_ready,
  input  logic                        fifo_full,
  output logic                        fifo_write,
  output logic [DATA_WIDTH-1:0]       fifo_write_data,
  output logic [N_REQ-1:0]            grant,
  output logic                        busy
`ifdef ARB_STATS_EN
  ,
  output logic [N_REQ*16-1:0]         xfer_count
`endif
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic [IDX_W-1:0]   owner;
  logic               owner_vld;
  logic               xfer;
  logic               release_now;
  logic [N_REQ-1:0]   pick;

  // First valid index at offsets last+1 .. last+N_REQ; 'last' itself is considered last.
  function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] vld,
                                               input logic [IDX_W-1:0] last);
    int idx;
    rr_pick = '0;
    for (int o = N_REQ; o >= 1; o--) begin
      idx = (int'(last) + o) % N_REQ;
      if (vld[idx]) rr_pick = N_REQ'(1) << idx;
    end
  endfunction

  always_comb begin
    owner           = '0;
    fifo_write_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) begin
        owner           = IDX_W'(i);
        fifo_write_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign owner_vld  = |(grant_q & req_valid);
  assign xfer       = owner_vld & ~fifo_full;
  assign fifo_write = xfer;
  assign req_ready  = grant_q & {N_REQ{~fifo_full}};
  assign grant      = grant_q;
  assign busy       = (state_q == GRANT);

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    burst_cnt_d = burst_cnt_q;
    release_now = 1'b0;
    pick        = '0;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          grant_d     = rr_pick(req_valid, last_q);
          burst_cnt_d = '0;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        // A stalled FIFO freezes the count, so only a dropped valid can release.
        release_now = ~owner_vld | (xfer & (burst_cnt_q == CNT_W'(MAX_BURST - 1)));
        if (release_now) begin
          last_d = owner;
          pick   = rr_pick(req_valid, owner);
          if (|pick) begin
            grant_d     = pick;
            burst_cnt_d = '0;
          end else begin
            grant_d = '0;
            state_d = IDLE;
          end
        end else if (xfer) begin
          burst_cnt_d = burst_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      last_q      <= IDX_W'(N_REQ - 1);
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

`ifdef ARB_STATS_EN
  logic [15:0] xfer_cnt_q [N_REQ];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_REQ; i++) xfer_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req_valid[i] && req_ready[i] && (xfer_cnt_q[i] != 16'hFFFF))
          xfer_cnt_q[i] <= xfer_cnt_q[i] + 16'd1;
      end
    end
  end

  always_comb begin
    xfer_count = '0;
    for (int i = 0; i < N_REQ; i++) xfer_count[i*16 +: 16] = xfer_cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: producer models feed words, a scoreboard
// holds the expected (grant, data) order of FIFO writes.
module tb_fifo_write_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;

  logic            clk;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            fifo_full;
  logic            fifo_write;
  logic [DW-1:0]   fifo_write_data;
  logic [N-1:0]    grant;
  logic            busy;
`ifdef ARB_STATS_EN
  logic [N*16-1:0] xfer_count;
`endif

  fifo_write_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(4)) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .fifo_full(fifo_full),
    .fifo_write(fifo_write),
    .fifo_write_data(fifo_write_data),
    .grant(grant),
    .busy(busy)
`ifdef ARB_STATS_EN
    ,
    .xfer_count(xfer_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]  g;
    logic [DW-1:0] d;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] src_mem [N][16];
  int            head [N];
  int            tail [N];
  logic [N-1:0]  en;
  int            checks;
  int            failures;
  int            extra_writes;
  int            n;

  function automatic logic [DW-1:0] w(input int i, input int k);
    return DW'(i * 64 + k);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input int i, input int k);
    src_mem[i][tail[i]] = w(i, k);
    tail[i]++;
  endtask

  task automatic expect_wr(input int i, input int k);
    exp_t e;
    e.g = N'(1) << i;
    e.d = w(i, k);
    sb.push_back(e);
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = en[i] && (head[i] < tail[i]);
      req_data[i*DW +: DW] = req_valid[i] ? src_mem[i][head[i]] : '0;
    end
  endtask

  // Sample on the falling edge, then advance producers past the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (fifo_write === 1'b1) begin
      if (sb.size() == 0) begin
        extra_writes++;
      end else begin
        e = sb.pop_front();
        check("wr_data", 64'(fifo_write_data), 64'(e.d));
        check("wr_grant", 64'(grant), 64'(e.g));
      end
    end
    for (int i = 0; i < N; i++)
      if (req_valid[i] && req_ready[i]) head[i]++;
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic drain(input string tag, input int max_cycles, output int cycles);
    cycles = 0;
    while (sb.size() != 0 && cycles < max_cycles) begin
      tick();
      cycles++;
    end
    check({tag, "_drain"}, 64'(sb.size()), 64'd0);
    repeat (3) tick();
    check({tag, "_extra_writes"}, 64'(extra_writes), 64'd0);
    check({tag, "_idle_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    fifo_full = 1'b0;
    en        = '0;
    req_valid = '0;
    req_data  = '0;
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    extra_writes = 0;
    do_reset();
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_fifo_write", 64'(fifo_write), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
`ifdef ARB_STATS_EN
    check("rst_xfer_count", 64'(xfer_count), 64'd0);
`endif

    // Single requester, 10 words: one bubble, then back-to-back self re-grants.
    for (int k = 0; k < 10; k++) begin
      push_word(0, k);
      expect_wr(0, k);
    end
    en = 4'b0001;
    drive();
    #1;
    check("t1_bubble_grant", 64'(grant), 64'd0);
    check("t1_bubble_busy", 64'(busy), 64'd0);
    tick();
    #1;
    check("t1_grant", 64'(grant), 64'h1);
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_fifo_write", 64'(fifo_write), 64'd1);
    drain("t1", 40, n);
    check("t1_cycles", 64'(n), 64'd10);

    // All four valid: bursts of four in order 0,1,2,3,0,1,2,3 without bubbles.
    do_reset();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 8; k++) push_word(i, k);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++)
        for (int k = 0; k < 4; k++) expect_wr(i, r * 4 + k);
    en = 4'b1111;
    drive();
    tick();
    drain("t2", 60, n);
    check("t2_cycles", 64'(n), 64'd32);

    // Early release: owner 2 drops valid after two words; 3 then 0 follow.
    do_reset();
    push_word(2, 0);
    push_word(2, 1);
    for (int k = 0; k < 4; k++) begin
      push_word(0, k);
      push_word(3, k);
    end
    expect_wr(2, 0);
    expect_wr(2, 1);
    for (int k = 0; k < 4; k++) expect_wr(3, k);
    for (int k = 0; k < 4; k++) expect_wr(0, k);
    en = 4'b0100;
    drive();
    tick();
    en = 4'b1101;
    drive();
    #1;
    check("t3_first_grant", 64'(grant), 64'h4);
    drain("t3", 40, n);

    // Backpressure: five full cycles after two words; burst still totals four.
    do_reset();
    for (int k = 0; k < 6; k++) push_word(1, k);
    push_word(3, 0);
    push_word(3, 1);
    for (int k = 0; k < 4; k++) expect_wr(1, k);
    expect_wr(3, 0);
    expect_wr(3, 1);
    expect_wr(1, 4);
    expect_wr(1, 5);
    en = 4'b1010;
    drive();
    repeat (3) tick();
    fifo_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("t4_full_ready", 64'(req_ready), 64'd0);
      check("t4_full_write", 64'(fifo_write), 64'd0);
      check("t4_full_grant", 64'(grant), 64'h2);
      tick();
    end
    fifo_full = 1'b0;
    drain("t4", 40, n);

    // Reset mid-burst: owner 2 loses its grant; priority restarts at requester 0.
    do_reset();
    push_word(1, 0);
    expect_wr(1, 0);
    en = 4'b0010;
    drive();
    drain("t5a", 10, n);
    for (int k = 0; k < 4; k++) push_word(2, k);
    expect_wr(2, 0);
    expect_wr(2, 1);
    en = 4'b0100;
    drive();
    repeat (3) tick();
    reset = 1'b1;
    en = '0;
    drive();
    tick();
    reset = 1'b0;
    #1;
    check("t5_rst_grant", 64'(grant), 64'd0);
    check("t5_rst_busy", 64'(busy), 64'd0);
`ifdef ARB_STATS_EN
    check("t5_rst_xfer_count", 64'(xfer_count), 64'd0);
`endif
    push_word(0, 0);
    push_word(0, 1);
    expect_wr(0, 0);
    expect_wr(0, 1);
    expect_wr(2, 2);
    expect_wr(2, 3);
    en = 4'b0101;
    drive();
    tick();
    #1;
    check("t5_first_grant", 64'(grant), 64'h1);
    drain("t5", 20, n);

`ifdef ARB_STATS_EN
    check("t6_pre_cnt0", 64'(xfer_count[15:0]), 64'd2);
    check("t6_pre_cnt2", 64'(xfer_count[47:32]), 64'd2);
    // Saturation: requester 1 streams far beyond 16 bits of transfers.
    en = '0;
    req_valid = 4'b0010;
    req_data  = 32'h0000_AA00;
    repeat (70010) @(posedge clk);
    #1;
    req_valid = '0;
    req_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("t6_cnt1_sat", 64'(xfer_count[31:16]), 64'hFFFF);
    check("t6_cnt0", 64'(xfer_count[15:0]), 64'd2);
    check("t6_cnt2", 64'(xfer_count[47:32]), 64'd2);
    check("t6_cnt3", 64'(xfer_count[63:48]), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
Shares one FIFO write port among N_REQ producers.
- Each producer uses a valid/ready handshake.
- Arbitration is round-robin with bounded bursts: a granted producer keeps the port for up to MAX_BURST accepted words.
- Sits directly in front of the FIFO write side (write, write_data, full), so several sources can merge into one queue without losing or reordering words per source.

Parameters:
- N_REQ, 4: number of requesters (2..8).
- DATA_WIDTH, 8: word width; equals the FIFO data width.
- MAX_BURST, 4: maximum accepted words per grant (1..255).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high.
- req_valid  input  N_REQ  per-requester word valid.
- req_data  input  N_REQ*DATA_WIDTH  flattened data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  output  N_REQ  per-requester accept.
- fifo_full  input  1  FIFO full flag.
- fifo_write  output  1  FIFO write strobe.
- fifo_write_data  output  DATA_WIDTH  FIFO write data.
- grant  output  N_REQ  one-hot current owner (all zero when idle).
- busy  output  1  high in state GRANT.

Behaviour:
- Reset: reset and clk exactly as stated under Ports (synchronous, active-high; clock clk). Reset values:
  - grant = 0, state = IDLE, busy = 0.
  - last_owner = N_REQ-1, so requester 0 has first priority.
  - burst_cnt = 0.
  - fifo_write = 0 and req_ready = 0 follow from grant = 0.
- Transfer definition: word i transfers when req_valid[i] & req_ready[i].
- Combinational outputs:
  - req_ready[i] = grant[i] & !fifo_full.
  - fifo_write = |(grant & req_valid) & !fifo_full.
  - fifo_write_data = req_data slice of the granted index; all zeros when grant = 0.
  - The FIFO samples fifo_write and fifo_write_data on the same edge as the transfer.
- State IDLE:
  - If any req_valid is high, register grant to the first valid index searching last_owner+1, last_owner+2, … (mod N_REQ).
  - On that grant: burst_cnt = 0, next state GRANT.
  - One bubble cycle from IDLE; no transfer occurs in IDLE.
- State GRANT, owner k:
  - Each transfer increments burst_cnt.
  - Release conditions:
    - (a) a transfer occurs with burst_cnt == MAX_BURST-1;
    - (b) req_valid[k] is low in this cycle.
  - On release: last_owner = k. In the same edge, re-arbitrate among the other requesters' valids, searching k+1 … k+N_REQ-1; k itself is eligible only last.
    - Winner found: stay in GRANT, new one-hot grant, burst_cnt = 0. This gives zero-bubble hand-over.
    - No winner: go to IDLE, grant = 0.
  - fifo_full high: grant is held, burst_cnt is frozen and there is no release by count. Release by (b) still applies.
- Burst counting:
  - burst_cnt width is clog2(MAX_BURST+1).
  - With MAX_BURST = 1, every transfer releases.
- Ordering and fairness:
  - Words from one requester reach the FIFO in issue order; no word is dropped or duplicated.
  - Worst-case wait for a continuously valid requester is (N_REQ-1)*MAX_BURST transfers plus fifo_full stall cycles.
- Requester contract: req_valid and req_data must stay stable until transfer. The arbiter does not check this.
- Reset mid-burst: grant clears on the reset edge. A word not yet transferred is not written.

Optional Feature:
- Macro: ARB_STATS_EN.
- When defined, adds output port xfer_count (N_REQ*16 bits, flattened like req_data).
  - One 16-bit counter per requester, incremented on each of its transfers.
  - Counters saturate at 16'hFFFF.
  - Cleared by reset.
- When undefined, the port and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Single requester: req_valid = 4'b0001 continuously, 10 words, fifo_full = 0 → grant = 4'b0001 after 1 idle cycle. Releases after every 4th transfer and, with no competitor, is re-granted with no bubble. FIFO receives the 10 words in order.
- All four continuously valid, MAX_BURST = 4 → grant sequence 0,1,2,3,0 with 4 words each and no bubbles between owners. fifo_write high every cycle after the first.
- Early release: owner 2 drops valid after 2 words while 0 and 3 are valid → next grant is requester 3 (round-robin from 2), then 0.
- Backpressure: fifo_full high for 5 cycles mid-burst → req_ready = 0 and fifo_write = 0 during those cycles. Grant and burst_cnt are held. The burst completes with the exact 4-word total after full drops.
- Reset mid-burst at word 2 → grant = 0 and busy = 0 next cycle. The first grant after reset goes to requester 0. With ARB_STATS_EN defined, xfer_count reads all zero.
- Saturation (ARB_STATS_EN): 70000 transfers from requester 1 → xfer_count slice 1 = 16'hFFFF. Other slices are unchanged.
